// File: rtl/debounced_counter_8bit.sv
// debounced_counter_8bit
// Counts debounced presses of a raw mechanical push-button and presents the
// running total, modulo 256, as a registered 8-bit value.
//
// The button is synchronized through two flops. A press registers only after
// the synchronized level has disagreed with the debounced state for
// DEBOUNCE_CYCLES consecutive clocks. One agreeing cycle restarts that wait.
// The count increments only on a debounced 0->1 edge, so a held button
// counts once. A release never changes the count.

module debounced_counter_8bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    output logic [7:0] count
);

    localparam int unsigned DBC_W    = 24;
    localparam int unsigned COUNT_W  = 8;
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [DBC_W-1:0]   r_dbc;
    logic [COUNT_W-1:0] r_count;

    logic w_disagree;
    logic w_window_done;
    logic w_press;

    // Decode the debounce decision for this cycle from the synchronized level.
    always_comb begin
        w_disagree    = (r_sync2 != r_stable);
        w_window_done = w_disagree && (r_dbc == DBC_LAST);
        w_press       = w_window_done && r_sync2;
    end

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce window: the stable level flips after N consecutive disagreeing cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_dbc    <= '0;
        end else if (!w_disagree) begin
            r_dbc <= '0;
        end else if (w_window_done) begin
            r_stable <= r_sync2;
            r_dbc    <= '0;
        end else begin
            r_dbc <= r_dbc + DBC_W'(1);
        end
    end

    // Press counter: one increment on the edge where the stable level rises.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_press) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_debounced_counter_8bit.sv
// Testbench for debounced_counter_8bit with DEBOUNCE_CYCLES = 4.
// The reference model keeps the raw button history and the last N samples
// of the synchronized level. It flips its debounced state when the whole
// window disagrees with that state.

module tb_debounced_counter_8bit;

    localparam int unsigned N = 4;

    logic       clock;
    logic       reset;
    logic       button;
    logic [7:0] count;

    debounced_counter_8bit #(.DEBOUNCE_CYCLES(N)) dut (
        .clock  (clock),
        .reset  (reset),
        .button (button),
        .count  (count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit       m_s1;
    bit       m_s2;
    bit       m_stable;
    bit [7:0] m_count;
    bit       hist[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit so the bench cannot hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_step();
        bit all_diff;
        if (reset) begin
            m_s1     = 1'b0;
            m_s2     = 1'b0;
            m_stable = 1'b0;
            m_count  = 8'd0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > N) void'(hist.pop_front());
            if (hist.size() == N) begin
                all_diff = 1'b1;
                foreach (hist[i]) if (hist[i] == m_stable) all_diff = 1'b0;
                if (all_diff) begin
                    m_stable = !m_stable;
                    hist.delete();
                    if (m_stable) m_count = m_count + 8'd1;
                end
            end
            m_s2 = m_s1;
            m_s1 = button;
        end
    endtask

    // One clock: update the model, take the edge, sample 1 ns later.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check("model", {24'd0, count}, {24'd0, m_count});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        ticks(cycles);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        button = 1'b0;

        // Long reset with the button idle, then release.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("reset_hold", {24'd0, count}, 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("after_reset", {24'd0, count}, 32'd0);
        end

        // Clean press with exact latency: five edges at 0, then 1 at edge k+5.
        button = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("press_latency", {24'd0, count}, 32'd0);
        end
        tick();
        check("press_edge", {24'd0, count}, 32'd1);
        ticks(20);
        check("press_held", {24'd0, count}, 32'd1);
        button = 1'b0;
        ticks(10);
        check("release", {24'd0, count}, 32'd1);

        // Bouncing press, then bouncing release.
        for (int b = 0; b < 4; b++) begin
            button = (b % 2 == 0);
            ticks(2);
        end
        check("bounce_press", {24'd0, count}, 32'd1);
        button = 1'b1;
        ticks(10);
        check("bounce_settled", {24'd0, count}, 32'd2);
        for (int b = 0; b < 4; b++) begin
            button = (b % 2 == 1);
            ticks(2);
        end
        button = 1'b0;
        ticks(10);
        check("bounce_release", {24'd0, count}, 32'd2);

        // Button held through reset counts once after reset is released.
        button = 1'b1;
        do_reset(5);
        check("held_reset", {24'd0, count}, 32'd0);
        ticks(10);
        check("held_after", {24'd0, count}, 32'd1);

        // Reset arriving mid-debounce restarts the window.
        button = 1'b0;
        do_reset(2);
        ticks(8);
        button = 1'b1;
        ticks(3);
        reset = 1'b1;
        tick();
        check("mid_reset", {24'd0, count}, 32'd0);
        reset = 1'b0;
        ticks(10);
        check("mid_after", {24'd0, count}, 32'd1);

        // Wrap-around across 257 clean presses.
        button = 1'b0;
        do_reset(2);
        ticks(8);
        for (int p = 1; p <= 257; p++) begin
            button = 1'b1;
            ticks(10);
            button = 1'b0;
            ticks(10);
            if (p == 255) check("wrap_255", {24'd0, count}, 32'd255);
            if (p == 256) check("wrap_256", {24'd0, count}, 32'd0);
            if (p == 257) check("wrap_257", {24'd0, count}, 32'd1);
        end

        // Random bouncy segments with occasional single-cycle resets.
        for (int s = 0; s < 400; s++) begin
            button = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            ticks($urandom_range(1, N + 3));
        end
        button = 1'b0;
        ticks(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
